lcd_count_display: RTL
======================

// Module: lcd_count_display
// PURPOSE
//  - Downstream consumer of the 8-bit press counter q from the button stage.
//  - Drives the Spartan-3E character LCD (HD44780, 4-bit mode, write-only).
//  - Runs the power-up init sequence, then shows "CNT:ddd" on line 1,
//    where ddd is q in decimal, 000..255.
//  - Rewrites the line whenever q changes.
// PARAMETERS
//  T_PWR   750000  cycles to wait after reset before the first nibble (15 ms at 50 MHz)
//  T_E     12      lcd_e high pulse width, in cycles (240 ns)
//  T_NIB   50      gap between the two nibbles of one byte, in cycles (1 us)
//  T_CMD   2000    wait after each byte, in cycles (40 us)
//  T_CLR   82000   wait after the clear-display byte 0x01, in cycles (1.64 ms)
// PORTS
//  clk     in   1  system clock, 50 MHz
//  rs      in   1  synchronous reset, active-high
//  value   in   8  counter value to display (the button stage's q)
//  lcd_d   out  4  LCD data nibble, SF_D[11:8]
//  lcd_e   out  1  LCD enable strobe
//  lcd_rs  out  1  LCD register select: 0 = command, 1 = data
//  lcd_rw  out  1  LCD read/write; tied to 0 (write only)
//  sf_ce0  out  1  StrataFlash chip enable; tied to 1 (flash off the bus)
//  ready   out  1  high when init is done and the displayed text matches the snapshot
// BEHAVIOUR
//  - One clock. Reset is synchronous, active-high, on rs.
//  - Reset values: lcd_d=0, lcd_e=0, lcd_rs=0, lcd_rw=0, sf_ce0=1, ready=0.
//    Reset also sets state to PWR, clears all counters, sets the snapshot to 0.
//  - Reset mid-operation aborts at once: lcd_e drops in the same cycle,
//    then the sequence restarts from PWR.
//  - States:
//    PWR  -> wait T_PWR -> INIT.
//    INIT -> send nibble 0x3 three times, then 0x2.
//            Each nibble: lcd_e high T_E cycles, then wait T_CMD.
//            -> CFG.
//    CFG  -> send bytes 0x28, 0x06, 0x0C, 0x01, with lcd_rs=0.
//            Wait T_CMD after each; wait T_CLR after 0x01.
//            -> REF.
//    REF  -> on entry, snapshot value.
//            Send command 0x80, then data 'C','N','T',':', then the hundreds,
//            tens and units digits as ASCII 0x30+d, with lcd_rs=1.
//            -> IDLE.
//    IDLE -> ready=1. If value != snapshot, go to REF (ready drops on that edge).
//  - Byte write: high nibble first.
//    Sequence: lcd_d/lcd_rs set up 1 cycle before lcd_e rises;
//    lcd_e high T_E; low T_NIB; low nibble, lcd_e high T_E; then wait T_CMD.
//  - lcd_d and lcd_rs are stable throughout every lcd_e-high window.
//  - value changes during REF do not alter the text being written.
//    IDLE catches the change and starts a new REF.
//  - A value equal to the snapshot on the return to IDLE causes no rewrite.
//  - Delay counter: 20 bits, down-counting. The wait ends when it reaches 0.
//  - Digits come from the combinational BCD of the snapshot.
//    Examples: 255 -> 2,5,5; 0 -> 0,0,0.
// CONFIGURATION
//  LCD_HEX_EN
//  - Defined: after the units digit, REF also writes command 0xC0, then data
//    'H',':' and two uppercase hex ASCII digits of the snapshot.
//    Example: 0xAF -> "H:AF".
//  - Not defined: line 2 is never written; the REF sequence ends at the units digit.
// STRUCTURE
//  Shared package / include:
//  - state encoding localparams: PWR, INIT, CFG, REF, IDLE;
//  - LCD command constants: 0x28, 0x06, 0x0C, 0x01, 0x80, 0xC0;
//  - the ASCII table for "CNT:" and "H:".
//  Sub-module lcd_bin2bcd: combinational double-dabble, 8 bits in, 3x4-bit BCD out.
//  Top holds the FSM, the delay counter, the step index and the nibble/strobe sequencer.
// TESTING (bench overrides T_PWR=20, T_E=2, T_NIB=3, T_CMD=5, T_CLR=10)
//  1. Reset, value=0 -> all outputs at reset values;
//     first lcd_e rise with lcd_d=0x3 occurs after 20 cycles.
//  2. Full init with value=0 -> nibble sequence 3,3,3,2, then
//     bytes 28,06,0C,01,80 (lcd_rs=0), then 43,4E,54,3A,30,30,30 (lcd_rs=1);
//     ready=1 at the end.
//  3. In IDLE, value 0->255 -> ready=0 next cycle; rewrite of 80,43,4E,54,3A,32,35,35.
//  4. value 7->9 in the middle of REF -> current pass writes "007",
//     then a second REF writes "009".
//  5. rs pulsed during the CFG byte 0x06 with lcd_e=1 -> lcd_e=0 the next cycle;
//     the sequence restarts at PWR.
//  6. LCD_HEX_EN defined, value=0xAF -> after "175", bytes C0,48,3A,41,46.

Source files
------------

// File: rtl/lcd_count_display_pkg.sv
// Shared constants for the character-LCD counter display: state/phase encodings,
// HD44780 commands, ASCII glyphs and the per-write item record.
package lcd_count_display_pkg;

  localparam logic [2:0] StPwr  = 3'd0;
  localparam logic [2:0] StInit = 3'd1;
  localparam logic [2:0] StCfg  = 3'd2;
  localparam logic [2:0] StRef  = 3'd3;
  localparam logic [2:0] StIdle = 3'd4;

  // Nibble/strobe sequencer phases
  localparam logic [2:0] PhLoad  = 3'd0;
  localparam logic [2:0] PhSetup = 3'd1;
  localparam logic [2:0] PhE     = 3'd2;
  localparam logic [2:0] PhGap   = 3'd3;
  localparam logic [2:0] PhWait  = 3'd4;
  localparam logic [2:0] PhIdle  = 3'd5;

  localparam logic [7:0] CmdFnSet  = 8'h28;
  localparam logic [7:0] CmdEntry  = 8'h06;
  localparam logic [7:0] CmdDispOn = 8'h0C;
  localparam logic [7:0] CmdClear  = 8'h01;
  localparam logic [7:0] CmdLine1  = 8'h80;
  localparam logic [7:0] CmdLine2  = 8'hC0;

  localparam logic [7:0] AsciiC     = 8'h43;
  localparam logic [7:0] AsciiN     = 8'h4E;
  localparam logic [7:0] AsciiT     = 8'h54;
  localparam logic [7:0] AsciiColon = 8'h3A;
  localparam logic [7:0] AsciiH     = 8'h48;
  localparam logic [7:0] AsciiZero  = 8'h30;

`ifdef LCD_HEX_EN
  localparam int unsigned RefLen = 13;
`else
  localparam int unsigned RefLen = 8;
`endif

  typedef struct packed {
    logic       rs;
    logic       is_byte;
    logic       clr;
    logic [7:0] data;
  } item_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (AsciiZero + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/lcd_count_display_bin2bcd.sv
// Combinational double-dabble: 8-bit binary to three BCD digits.
module lcd_bin2bcd (
  input  logic [7:0] bin_i,
  output logic [3:0] hund_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  logic [19:0] sh;

  always_comb begin
    sh = {12'd0, bin_i};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8] >= 4'd5)  sh[11:8]  = sh[11:8] + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = sh << 1;
    end
    hund_o = sh[19:16];
    tens_o = sh[15:12];
    ones_o = sh[11:8];
  end

endmodule

// File: rtl/lcd_count_display.sv
// HD44780 4-bit write-only driver showing "CNT:ddd" for an 8-bit counter.
// Define LCD_HEX_EN to also write "H:xx" on line 2.
module lcd_count_display
  import lcd_count_display_pkg::*;
#(
  parameter int unsigned T_PWR = 750000,
  parameter int unsigned T_E   = 12,
  parameter int unsigned T_NIB = 50,
  parameter int unsigned T_CMD = 2000,
  parameter int unsigned T_CLR = 82000
) (
  input  logic       clk_i,
  input  logic       rs_i,
  input  logic [7:0] value_i,
  output logic [3:0] lcd_d_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       sf_ce0_o,
  output logic       ready_o
);

  logic [2:0]  state_q, state_d, phase_q, phase_d;
  logic [19:0] cnt_q, cnt_d, cnt_dec;
  logic [3:0]  step_q, step_d, last_step;
  logic        lo_q, lo_d, lcd_e_q, lcd_e_d;
  logic [7:0]  snap_q, snap_d;
  item_t       item_q, item_d, nxt;
  logic        advance, start;
  logic [3:0]  hund, tens, ones;
  logic [8*RefLen-1:0] ref_text;
  logic [63:0] line1_text;

  lcd_bin2bcd u_bcd (
    .bin_i  (snap_q),
    .hund_o (hund),
    .tens_o (tens),
    .ones_o (ones)
  );

  // Byte k of the refresh sequence sits at ref_text[8k +: 8]
  assign line1_text = {4'h3, ones, 4'h3, tens, 4'h3, hund, AsciiColon, AsciiT, AsciiN, AsciiC,
                       CmdLine1};
`ifdef LCD_HEX_EN
  assign ref_text = {hex_ascii(snap_q[3:0]), hex_ascii(snap_q[7:4]), AsciiColon, AsciiH,
                     CmdLine2, line1_text};
`else
  assign ref_text = line1_text;
`endif

  function automatic item_t item_f(input logic [2:0] st, input logic [3:0] step,
                                   input logic [8*RefLen-1:0] text);
    item_t it;
    it = '0;
    it.is_byte = 1'b1;
    case (st)
      StInit: begin
        it.is_byte = 1'b0;
        it.data    = (step == 4'd3) ? 8'h02 : 8'h03;
      end
      StCfg: begin
        case (step)
          4'd0:    it.data = CmdFnSet;
          4'd1:    it.data = CmdEntry;
          4'd2:    it.data = CmdDispOn;
          default: begin
            it.data = CmdClear;
            it.clr  = 1'b1;
          end
        endcase
      end
      StRef: begin
        it.data = text[8*step +: 8];
        it.rs   = (step != 4'd0) && (step != 4'd8);
      end
      default: it.data = 8'h00;
    endcase
    return it;
  endfunction

  assign cnt_dec   = cnt_q - 20'd1;
  assign last_step = (state_q == StRef) ? 4'(RefLen - 1) : 4'd3;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    lo_d    = lo_q;
    snap_d  = snap_q;
    item_d  = item_q;
    lcd_e_d = 1'b0;
    advance = 1'b0;
    start   = 1'b0;
    case (phase_q)
      // The load cycle itself counts toward the power-up wait
      PhLoad: begin
        cnt_d   = 20'(T_PWR - 2);
        phase_d = PhWait;
      end
      PhSetup: begin
        cnt_d   = 20'(T_E - 1);
        phase_d = PhE;
        lcd_e_d = 1'b1;
      end
      PhE: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_dec;
          lcd_e_d = 1'b1;
        end else if (item_q.is_byte && !lo_q) begin
          phase_d = PhGap;
          cnt_d   = 20'(T_NIB - 1);
          lo_d    = 1'b1;
        end else begin
          phase_d = PhWait;
          cnt_d   = item_q.clr ? 20'(T_CLR - 1) : 20'(T_CMD - 1);
          lo_d    = 1'b0;
        end
      end
      PhGap: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_dec;
        end else begin
          phase_d = PhE;
          cnt_d   = 20'(T_E - 1);
          lcd_e_d = 1'b1;
        end
      end
      PhWait: begin
        if (cnt_q != '0) cnt_d = cnt_dec;
        else             advance = 1'b1;
      end
      PhIdle: begin
        if (value_i != snap_q) begin
          state_d = StRef;
          step_d  = '0;
          snap_d  = value_i;
          start   = 1'b1;
        end
      end
      default: phase_d = PhLoad;
    endcase

    if (advance) begin
      step_d = '0;
      if (state_q != StPwr && step_q != last_step) begin
        step_d = step_q + 4'd1;
        start  = 1'b1;
      end else begin
        case (state_q)
          StPwr: begin
            state_d = StInit;
            start   = 1'b1;
          end
          StInit: begin
            state_d = StCfg;
            start   = 1'b1;
          end
          StCfg: begin
            state_d = StRef;
            snap_d  = value_i;
            start   = 1'b1;
          end
          default: begin
            state_d = StIdle;
            phase_d = PhIdle;
          end
        endcase
      end
    end

    // lcd_d/lcd_rs change here, one cycle ahead of the strobe
    nxt = item_f(state_d, step_d, ref_text);
    if (start) begin
      phase_d = PhSetup;
      item_d  = nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rs_i) begin
      state_q <= StPwr;
      phase_q <= PhLoad;
      cnt_q   <= '0;
      step_q  <= '0;
      lo_q    <= 1'b0;
      snap_q  <= '0;
      item_q  <= '0;
      lcd_e_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      lo_q    <= lo_d;
      snap_q  <= snap_d;
      item_q  <= item_d;
      lcd_e_q <= lcd_e_d;
    end
  end

  assign lcd_d_o  = (item_q.is_byte && !lo_q) ? item_q.data[7:4] : item_q.data[3:0];
  assign lcd_e_o  = lcd_e_q;
  assign lcd_rs_o = item_q.rs;
  assign lcd_rw_o = 1'b0;
  assign sf_ce0_o = 1'b1;
  assign ready_o  = (state_q == StIdle);

endmodule
